int_to_fp_converter: RTL and testbench
======================================

INT_TO_FP_CONVERTER -- requirements
Module: int_to_fp_converter

Interface
REQ-001 Parameter IN_WIDTH, default 32, integer input width; legal range 2..64.
REQ-002 Parameter ROUND_MODE, default 0, rounding mode: 0 = round-to-nearest-even, 1 = truncate toward zero.
REQ-003 Port clk  input  1  the single clock; all state SHALL update on the rising edge.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Port in_valid  input  1  in_data/in_signed valid.
REQ-006 Port in_ready  output  1  block can accept an operand.
REQ-007 Port in_data  input  IN_WIDTH  integer operand.
REQ-008 Port in_signed  input  1  1 = two's complement, 0 = unsigned; sampled with in_data.
REQ-009 Port out_valid  output  1  out_data/out_inexact valid.
REQ-010 Port out_ready  input  1  consumer accepts the result.
REQ-011 Port out_data  output  32  IEEE-754 single-precision result.
REQ-012 Port out_inexact  output  1  result differs from the exact integer value.

Function
REQ-013 The FSM SHALL have states IDLE, NORM, ROUND and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; an operand SHALL be accepted on an edge where in_valid && in_ready.
REQ-015 On accept, the block SHALL register sign = in_signed & in_data[MSB] and magnitude = |in_data| as an IN_WIDTH-bit unsigned value; -2^(IN_WIDTH-1) SHALL give magnitude 2^(IN_WIDTH-1).
REQ-016 On accept, the exponent register SHALL load 127 + IN_WIDTH - 1, held at 9 bits or wider.
REQ-017 A zero magnitude SHALL go IDLE->DONE with out_data = 0x00000000 (positive zero) and out_inexact = 0.
REQ-018 A nonzero magnitude SHALL go IDLE->NORM.
REQ-019 In NORM, each cycle with magnitude MSB = 0 SHALL shift the magnitude left by 1 and decrement the exponent; the cycle with MSB = 1 SHALL go to ROUND.
REQ-020 ROUND SHALL take the mantissa from the 23 bits below the MSB, zero-padded on the right when IN_WIDTH <= 24.
REQ-021 ROUND SHALL compute guard as the next bit below the mantissa and sticky as the OR of all remaining bits.
REQ-022 For ROUND_MODE 0, ROUND SHALL increment the mantissa when guard & (sticky | mantissa LSB).
REQ-023 When rounding carries out of the mantissa, the mantissa SHALL become 0 and the exponent SHALL increment.
REQ-024 ROUND SHALL set out_inexact = guard | sticky, then go to DONE.
REQ-025 Latency: for a nonzero operand with lz leading zeros, out_valid SHALL rise on edge lz+3 after the accept edge; for zero, on edge 1.
REQ-026 In DONE, out_valid SHALL be 1 and out_data/out_inexact SHALL stay stable until an edge with out_ready = 1, which returns the FSM to IDLE.
REQ-027 out_valid and in_ready SHALL never both be 1 in the same cycle (no overlap, one conversion in flight).
REQ-028 out_data SHALL be registered and SHALL hold its last value outside DONE.

Reset
REQ-029 Asserting rst at any time, including mid-conversion, SHALL immediately force IDLE and discard the operation in flight.
REQ-030 During reset, in_ready SHALL read 1 only after rst deasserts, out_valid = 0, out_data = 0x00000000 and out_inexact = 0.

Structure
REQ-031 Shared package int_to_fp_pkg SHALL hold the state encoding and the FP32 constants BIAS = 127, EXP_W = 8 and MANT_W = 23.
REQ-032 Rounding SHALL sit in one combinational sub-module, fp_round, with inputs mantissa, guard, sticky and mode, and outputs rounded mantissa, carry and inexact.

Verification
REQ-033 Unsigned 5 -> 0x40A00000, inexact 0, out_valid on edge 32 (lz = 29); unsigned 124 -> 0x42F80000; 0 -> 0x00000000 on edge 1.
REQ-034 Signed -1 -> 0xBF800000; signed 0x80000000 -> 0xCF000000; unsigned 0x80000000 -> 0x4F000000.
REQ-035 Rounding, RNE: 0x01000001 -> 0x4B800000 (tie, even, inexact 1); 0x01000003 -> 0x4B800002; unsigned 0xFFFFFFFF -> 0x4F800000 (carry, inexact 1).
REQ-036 Rounding, ROUND_MODE 1: unsigned 0xFFFFFFFF -> 0x4F7FFFFF with inexact 1.
REQ-037 Backpressure: hold out_ready = 0 for 5 cycles in DONE -> out_data stable and in_ready = 0 throughout; a new in_valid is accepted only after the handshake.
REQ-038 Reset in NORM: out_valid = 0 and FSM in IDLE immediately; the next operand (2) -> 0x40000000 with normal latency.
REQ-039 IN_WIDTH = 8 instance: unsigned 0xFF -> 0x437F0000 (exact); signed 0x80 -> 0xC3000000.

Source files
------------

// File: rtl/int_to_fp_pkg.sv
// Shared definitions for the integer to FP32 converter: FSM encoding and FP32 field constants.
package int_to_fp_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StNorm  = 2'd1,
    StRound = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned BIAS   = 127;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  // Working exponent is one bit wider than the FP32 field so the load value never wraps.
  localparam int unsigned EXPR_W = 9;

  // Exponent of an operand whose MSB is already at bit in_width-1.
  function automatic logic [EXPR_W-1:0] exp_load(input int unsigned in_width);
    return EXPR_W'(BIAS + in_width - 1);
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational mantissa rounding: round-to-nearest-even (mode 0) or truncate (mode 1).
module fp_round
  import int_to_fp_pkg::*;
(
  input  logic [MANT_W-1:0] i_mant,
  input  logic              i_guard,
  input  logic              i_sticky,
  input  logic              i_mode,
  output logic [MANT_W-1:0] o_mant,
  output logic              o_carry,
  output logic              o_inexact
);

  logic            w_round_up;
  logic [MANT_W:0] w_sum;

  // Increment on guard with sticky or odd LSB; a carry leaves the low bits zero.
  always_comb begin
    w_round_up = ~i_mode & i_guard & (i_sticky | i_mant[0]);
    w_sum      = {1'b0, i_mant} + {{MANT_W{1'b0}}, w_round_up};
    o_mant     = w_sum[MANT_W-1:0];
    o_carry    = w_sum[MANT_W];
    o_inexact  = i_guard | i_sticky;
  end

endmodule

// File: rtl/int_to_fp_converter.sv
// Multi-cycle integer to IEEE-754 single-precision converter with valid/ready handshakes.
// Normalisation shifts one bit per cycle, so latency depends on the leading-zero count.
module int_to_fp_converter
  import int_to_fp_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 32,
  parameter int unsigned ROUND_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_WIDTH-1:0] in_data,
  input  logic                in_signed,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_data,
  output logic                out_inexact
);

  // Fraction below the leading one, padded so guard and sticky always exist.
  localparam int unsigned FRAC_W = IN_WIDTH - 1 + MANT_W + 2;
  localparam logic [EXPR_W-1:0] ExpLoad = exp_load(IN_WIDTH);
  localparam logic [EXPR_W-1:0] ExpOne  = EXPR_W'(1);

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_sign;
  logic [IN_WIDTH-1:0]   r_mag;
  logic [EXPR_W-1:0]     r_exp;
  logic [31:0]           r_out_data;
  logic                  r_out_inexact;

  logic                  w_accept;
  logic                  w_neg;
  logic [IN_WIDTH-1:0]   w_in_mag;
  logic                  w_in_zero;
  logic [FRAC_W-1:0]     w_frac;
  logic [MANT_W-1:0]     w_mant;
  logic                  w_guard;
  logic                  w_sticky;
  logic [MANT_W-1:0]     w_mant_rnd;
  logic                  w_carry;
  logic                  w_inexact;
  logic [EXP_W-1:0]      w_exp_final;

  // Operand decode: sign and absolute value; the most negative value maps to 2^(IN_WIDTH-1).
  always_comb begin
    w_accept  = in_valid & in_ready;
    w_neg     = in_signed & in_data[IN_WIDTH-1];
    w_in_mag  = w_neg ? ((~in_data) + {{(IN_WIDTH-1){1'b0}}, 1'b1}) : in_data;
    w_in_zero = (w_in_mag == '0);
  end

  // Field extraction for rounding and the final exponent after a possible mantissa carry.
  always_comb begin
    w_frac      = {r_mag[IN_WIDTH-2:0], {(MANT_W + 2){1'b0}}};
    w_mant      = w_frac[FRAC_W-1 -: MANT_W];
    w_guard     = w_frac[FRAC_W-MANT_W-1];
    w_sticky    = |w_frac[FRAC_W-MANT_W-2:0];
    w_exp_final = r_exp[EXP_W-1:0] + {{(EXP_W-1){1'b0}}, w_carry};
  end

  fp_round u_fp_round (
    .i_mant    (w_mant),
    .i_guard   (w_guard),
    .i_sticky  (w_sticky),
    .i_mode    (ROUND_MODE[0]),
    .o_mant    (w_mant_rnd),
    .o_carry   (w_carry),
    .o_inexact (w_inexact)
  );

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = w_in_zero ? StDone : StNorm;
      end
      StNorm: begin
        if (r_mag[IN_WIDTH-1]) w_state_next = StRound;
      end
      StRound: w_state_next = StDone;
      StDone: begin
        if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Datapath: load on accept, normalise one bit per cycle, capture the result in ROUND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign        <= 1'b0;
      r_mag         <= '0;
      r_exp         <= '0;
      r_out_data    <= '0;
      r_out_inexact <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_sign <= w_neg;
            r_mag  <= w_in_mag;
            r_exp  <= ExpLoad;
            if (w_in_zero) begin
              r_out_data    <= '0;
              r_out_inexact <= 1'b0;
            end
          end
        end
        StNorm: begin
          if (!r_mag[IN_WIDTH-1]) begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - ExpOne;
          end
        end
        StRound: begin
          r_out_data    <= {r_sign, w_exp_final, w_mant_rnd};
          r_out_inexact <= w_inexact;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs; in_ready is held low while reset is asserted.
  always_comb begin
    in_ready    = (r_state == StIdle) & ~rst;
    out_valid   = (r_state == StDone);
    out_data    = r_out_data;
    out_inexact = r_out_inexact;
  end

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Self-checking bench: three instances (32-bit RNE, 32-bit truncate, 8-bit RNE), a vector table,
// hand-written backpressure and reset sequences, and randomized operands against a numeric model.
module tb_int_to_fp_converter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid    [3];
  logic        in_ready    [3];
  logic [31:0] in_data     [3];
  logic        in_signed   [3];
  logic        out_valid   [3];
  logic        out_ready   [3];
  logic [31:0] out_data    [3];
  logic        out_inexact [3];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  int_to_fp_converter #(.IN_WIDTH(32), .ROUND_MODE(0)) u_dut_rne (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_signed(in_signed[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .out_inexact(out_inexact[0])
  );

  int_to_fp_converter #(.IN_WIDTH(32), .ROUND_MODE(1)) u_dut_trunc (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_signed(in_signed[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .out_inexact(out_inexact[1])
  );

  int_to_fp_converter #(.IN_WIDTH(8), .ROUND_MODE(0)) u_dut_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][7:0]), .in_signed(in_signed[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]), .out_inexact(out_inexact[2])
  );

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic        sgn;
    logic [31:0] exp_data;
    logic        exp_inex;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Numeric reference: locate the leading one, scale, round on the remainder.
  function automatic void ref_model(input int w, input logic [63:0] v, input logic sgn,
                                    input int mode, output logic [31:0] res,
                                    output logic inex, output int lat);
    logic [63:0] mag, sig, rem, half;
    logic        neg;
    int          p, e;
    neg = sgn && v[w-1];
    mag = neg ? ((64'd1 << w) - v) : v;
    if (mag == 0) begin
      res = 32'h0; inex = 1'b0; lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    if (p >= 23) begin
      sig  = mag >> (p - 23);
      rem  = mag - (sig << (p - 23));
      half = (p >= 24) ? (64'd1 << (p - 24)) : 64'd0;
    end else begin
      sig  = mag << (23 - p);
      rem  = 0;
      half = 0;
    end
    inex = (rem != 0);
    if (mode == 0 && rem != 0 && (rem > half || (rem == half && sig[0]))) sig = sig + 1;
    e = p + 127;
    if (sig == (64'd1 << 24)) begin
      sig = sig >> 1;
      e++;
    end
    res = {neg, 8'(e), sig[22:0]};
    lat = (w - 1 - p) + 3;
  endfunction

  // Present an operand from a negedge and return #1 after the accept edge.
  task automatic issue(input int d, input logic [31:0] data, input logic sgn);
    int n;
    n = 0;
    @(negedge clk);
    in_valid[d]  = 1'b1;
    in_data[d]   = data;
    in_signed[d] = sgn;
    while (!in_ready[d] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[d]) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout: in_ready stayed %b, expected 1", in_ready[d]);
    end
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
  endtask

  // Called #1 after the accept edge (edge 1); counts edges until out_valid.
  task automatic wait_result(input int d, output logic [31:0] res, output logic inex,
                             output int lat);
    lat = 1;
    while (!out_valid[d] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid[d]) begin
      n_vec++; n_err++;
      $display("FAIL result_timeout: out_valid stayed 0, expected 1 within 200 edges");
      lat = -1;
    end
    check("no_overlap", 64'(in_ready[d]), 64'd0);
    res  = out_data[d];
    inex = out_inexact[d];
  endtask

  task automatic convert(input int d, input logic [31:0] data, input logic sgn,
                         output logic [31:0] res, output logic inex, output int lat);
    issue(d, data, sgn);
    wait_result(d, res, inex, lat);
  endtask

  vec_t        vecs [13];
  logic [31:0] res, ref_res, held;
  logic        inex, ref_inex;
  int          lat, ref_lat;

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_data[i] = '0; in_signed[i] = 1'b0; out_ready[i] = 1'b1;
    end

    vecs[0]  = '{0, 32'h0000_0005, 1'b0, 32'h40A0_0000, 1'b0, 32};
    vecs[1]  = '{0, 32'h0000_007C, 1'b0, 32'h42F8_0000, 1'b0, 28};
    vecs[2]  = '{0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1};
    vecs[3]  = '{0, 32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 1'b0, 34};
    vecs[4]  = '{0, 32'h8000_0000, 1'b1, 32'hCF00_0000, 1'b0, 3};
    vecs[5]  = '{0, 32'h8000_0000, 1'b0, 32'h4F00_0000, 1'b0, 3};
    vecs[6]  = '{0, 32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1, 10};
    vecs[7]  = '{0, 32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1, 10};
    vecs[8]  = '{0, 32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 1'b1, 3};
    vecs[9]  = '{1, 32'hFFFF_FFFF, 1'b0, 32'h4F7F_FFFF, 1'b1, 3};
    vecs[10] = '{2, 32'h0000_00FF, 1'b0, 32'h437F_0000, 1'b0, 3};
    vecs[11] = '{2, 32'h0000_0080, 1'b1, 32'hC300_0000, 1'b0, 3};
    vecs[12] = '{2, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1};

    // Outputs while reset is held.
    #3;
    check("rst_in_ready",    64'(in_ready[0]),    64'd0);
    check("rst_out_valid",   64'(out_valid[0]),   64'd0);
    check("rst_out_data",    64'(out_data[0]),    64'd0);
    check("rst_out_inexact", 64'(out_inexact[0]), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready[0]), 64'd1);

    // Directed table.
    foreach (vecs[i]) begin
      convert(vecs[i].dut, vecs[i].data, vecs[i].sgn, res, inex, lat);
      check($sformatf("vec%0d_data", i), 64'(res), 64'(vecs[i].exp_data));
      check($sformatf("vec%0d_inexact", i), 64'(inex), 64'(vecs[i].exp_inex));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
    end

    // Backpressure: result must hold for 5 cycles, and a waiting operand must not be taken.
    out_ready[0] = 1'b0;
    convert(0, 32'd7, 1'b0, res, inex, lat);
    held = res;
    check("bp_first_data", 64'(res), 64'h40E0_0000);
    @(negedge clk);
    in_valid[0] = 1'b1; in_data[0] = 32'd9; in_signed[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_data_%0d", c), 64'(out_data[0]), 64'(held));
      check($sformatf("bp_hold_valid_%0d", c), 64'(out_valid[0]), 64'd1);
      check($sformatf("bp_hold_ready_%0d", c), 64'(in_ready[0]), 64'd0);
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ready", 64'(in_ready[0]), 64'd1);
    check("bp_release_valid", 64'(out_valid[0]), 64'd0);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    wait_result(0, res, inex, lat);
    check("bp_second_data", 64'(res), 64'h4110_0000);
    check("bp_second_latency", 64'(lat), 64'd31);

    // Reset while normalising a long operand.
    issue(0, 32'd1, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid[0]), 64'd0);
    check("midrst_in_ready",  64'(in_ready[0]),  64'd0);
    check("midrst_out_data",  64'(out_data[0]),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_idle_ready", 64'(in_ready[0]), 64'd1);
    convert(0, 32'd2, 1'b0, res, inex, lat);
    check("midrst_next_data", 64'(res), 64'h4000_0000);
    check("midrst_next_latency", 64'(lat), 64'd33);

    // Randomized operands against the numeric model.
    for (int i = 0; i < 150; i++) begin
      int          d, w;
      logic [31:0] data;
      logic        sgn;
      d    = $urandom_range(0, 2);
      w    = (d == 2) ? 8 : 32;
      data = $urandom >> $urandom_range(0, 31);
      if (w == 8) data = data & 32'hFF;
      sgn  = 1'($urandom_range(0, 1));
      ref_model(w, 64'(data), sgn, (d == 1) ? 1 : 0, ref_res, ref_inex, ref_lat);
      convert(d, data, sgn, res, inex, lat);
      check($sformatf("rnd%0d_d%0d_%h_s%0d_data", i, d, data, sgn), 64'(res), 64'(ref_res));
      check($sformatf("rnd%0d_inexact", i), 64'(inex), 64'(ref_inex));
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'(ref_lat));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
